// File: rtl/l2_pkg.sv
// Shared types and sizing for the L2 host tag tracker.
// Optional statistics build: L2_TAG_STATS_EN.
package l2_pkg;

  localparam int ADDR_WIDTH   = 64;
  localparam int NSTRMS       = 64;
  localparam int NSTRMS_WIDTH = $clog2(NSTRMS);
  localparam int NTAGS        = 32;
  localparam int TAG_WIDTH    = $clog2(NTAGS);
  localparam int FIFO_DEPTH   = 4;
  localparam int PTR_WIDTH    = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH    = PTR_WIDTH + 1;

  typedef logic [TAG_WIDTH-1:0]    l2_tag_t;
  typedef logic [NSTRMS_WIDTH-1:0] l2_sid_t;
  typedef logic [ADDR_WIDTH-1:0]   l2_ea_t;

  typedef struct packed {
    l2_ea_t  ea;
    l2_sid_t sid;
  } l2_req_t;

endpackage

// File: rtl/l2_host_tag_tracker_if.sv
// Request, host command, host response and sid response channels.
// Optional statistics build: L2_TAG_STATS_EN.
interface l2_host_tag_tracker_if;
  import l2_pkg::*;

  logic    i_req_v;
  logic    i_req_r;
  l2_sid_t i_req_sid;
  l2_ea_t  i_req_ea;
  logic    o_cmd_v;
  logic    o_cmd_r;
  l2_tag_t o_cmd_tag;
  l2_ea_t  o_cmd_ea;
  logic    i_host_v;
  logic    i_host_r;
  l2_tag_t i_host_tag;
  logic    o_rsp_v;
  logic    o_rsp_r;
  l2_sid_t o_rsp_sid;

  modport master (
    output i_req_v, i_req_sid, i_req_ea,
    output o_cmd_r, i_host_v, i_host_tag,
    output o_rsp_r,
    input  i_req_r, o_cmd_v, o_cmd_tag,
    input  o_cmd_ea, i_host_r, o_rsp_v,
    input  o_rsp_sid
  );

  modport slave (
    input  i_req_v, i_req_sid, i_req_ea,
    input  o_cmd_r, i_host_v, i_host_tag,
    input  o_rsp_r,
    output i_req_r, o_cmd_v, o_cmd_tag,
    output o_cmd_ea, i_host_r, o_rsp_v,
    output o_rsp_sid
  );

endinterface

// File: rtl/l2_tag_freelist.sv
// Host tag free bitmap with lowest-index-free allocation.
// Optional statistics build: L2_TAG_STATS_EN (in-use count).
module l2_tag_freelist
  import l2_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    alloc,
  output l2_tag_t alloc_tag,
  input  logic    rel,
  input  l2_tag_t rel_tag,
  input  l2_tag_t lookup_tag,
  output logic    in_use,
  output logic    full,
  output logic    empty
`ifdef L2_TAG_STATS_EN
  ,
  output logic [TAG_WIDTH:0] used_cnt
`endif
);

  logic [NTAGS-1:0] free_map;

  assign full   = ~|free_map;
  assign empty  = &free_map;
  assign in_use = ~free_map[lookup_tag];

`ifdef L2_TAG_STATS_EN
  assign used_cnt = (TAG_WIDTH+1)'($countones(~free_map));
`endif

  // Scan downward so the lowest free index wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS-1; i >= 0; i--)
      if (free_map[i]) alloc_tag = l2_tag_t'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_map <= '1;
    end else begin
      if (alloc) free_map[alloc_tag] <= 1'b0;
      if (rel)   free_map[rel_tag]   <= 1'b1;
    end
  end

endmodule

// File: rtl/l2_host_tag_tracker.sv
// Buffers merged host reads, tags them, and maps host tags back to sids.
// Optional statistics build: L2_TAG_STATS_EN.
module l2_host_tag_tracker
  import l2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  l2_host_tag_tracker_if.slave bus,
  output logic o_err,
  output logic o_busy
`ifdef L2_TAG_STATS_EN
  ,
  output logic [31:0]        o_stat_issued,
  output logic [TAG_WIDTH:0] o_stat_peak
`endif
);

  l2_req_t               mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wptr, rptr;
  logic [CNT_WIDTH-1:0]  cnt;
  l2_sid_t               sid_tbl [NTAGS];
  l2_req_t               head;
  logic                  push, load, host_acc, rel;
  logic                  cmd_v, rsp_v;
  l2_tag_t               cmd_tag, alloc_tag;
  l2_ea_t                cmd_ea;
  l2_sid_t               rsp_sid;
  logic                  tag_in_use, tags_full, tags_empty;
`ifdef L2_TAG_STATS_EN
  logic [TAG_WIDTH:0]    used_cnt;
`endif

  assign head     = mem[rptr];
  assign bus.i_req_r = cnt != CNT_WIDTH'(FIFO_DEPTH);
  assign push     = bus.i_req_v & bus.i_req_r;
  assign load     = (cnt != '0) & (~cmd_v | bus.o_cmd_r)
                  & ~tags_full;
  assign bus.i_host_r = ~rsp_v | bus.o_rsp_r;
  assign host_acc = bus.i_host_v & bus.i_host_r;
  assign rel      = host_acc & tag_in_use;

  assign bus.o_cmd_v   = cmd_v;
  assign bus.o_cmd_tag = cmd_tag;
  assign bus.o_cmd_ea  = cmd_ea;
  assign bus.o_rsp_v   = rsp_v;
  assign bus.o_rsp_sid = rsp_sid;
  assign o_busy = (cnt != '0) | ~tags_empty;

  l2_tag_freelist u_freelist (
    .clk        (clk),
    .reset      (reset),
    .alloc      (load),
    .alloc_tag  (alloc_tag),
    .rel        (rel),
    .rel_tag    (bus.i_host_tag),
    .lookup_tag (bus.i_host_tag),
    .in_use     (tag_in_use),
    .full       (tags_full),
    .empty      (tags_empty)
`ifdef L2_TAG_STATS_EN
    ,
    .used_cnt   (used_cnt)
`endif
  );

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{ea: bus.i_req_ea,
                             sid: bus.i_req_sid};
    if (load) sid_tbl[alloc_tag] <= head.sid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      cmd_v   <= 1'b0;
      cmd_tag <= '0;
      cmd_ea  <= '0;
      rsp_v   <= 1'b0;
      rsp_sid <= '0;
      o_err   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      cnt <= cnt + CNT_WIDTH'(push) - CNT_WIDTH'(load);
      if (load) begin
        cmd_v   <= 1'b1;
        cmd_tag <= alloc_tag;
        cmd_ea  <= head.ea;
      end else if (bus.o_cmd_r) begin
        cmd_v <= 1'b0;
      end
      if (rel) begin
        rsp_v   <= 1'b1;
        rsp_sid <= sid_tbl[bus.i_host_tag];
      end else if (bus.o_rsp_r) begin
        rsp_v <= 1'b0;
      end
      // Unknown tags are dropped; only flag them.
      o_err <= host_acc & ~tag_in_use;
    end
  end

`ifdef L2_TAG_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_stat_issued <= '0;
      o_stat_peak   <= '0;
    end else begin
      if (cmd_v & bus.o_cmd_r)
        o_stat_issued <= o_stat_issued + 1'b1;
      if (used_cnt > o_stat_peak)
        o_stat_peak <= used_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_l2_host_tag_tracker.sv
// Directed bench for l2_host_tag_tracker.
// Optional statistics build: L2_TAG_STATS_EN.
module tb_l2_host_tag_tracker;
  import l2_pkg::*;

  logic clk;
  logic reset;
  logic o_err, o_busy;
`ifdef L2_TAG_STATS_EN
  logic [31:0]        o_stat_issued;
  logic [TAG_WIDTH:0] o_stat_peak;
`endif

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    l2_tag_t tag;
    l2_ea_t  ea;
  } rec_t;
  rec_t q[$];

  l2_host_tag_tracker_if bus ();

  l2_host_tag_tracker dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .o_err  (o_err),
    .o_busy (o_busy)
`ifdef L2_TAG_STATS_EN
    ,
    .o_stat_issued (o_stat_issued),
    .o_stat_peak   (o_stat_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && bus.o_cmd_v && bus.o_cmd_r)
      q.push_back('{bus.o_cmd_tag, bus.o_cmd_ea});

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int sid, input logic [63:0] ea);
    int n = 0;
    bus.i_req_v   = 1'b1;
    bus.i_req_sid = l2_sid_t'(sid);
    bus.i_req_ea  = ea;
    while (!bus.i_req_r && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("req_ready_wait", bus.i_req_r, 1);
    tick();
    bus.i_req_v = 1'b0;
  endtask

  task automatic host(input int tag);
    bus.i_host_v   = 1'b1;
    bus.i_host_tag = l2_tag_t'(tag);
    tick();
    bus.i_host_v = 1'b0;
  endtask

  initial begin
    int bad;
    int unst;
    reset          = 1'b0;
    bus.i_req_v    = 1'b0;
    bus.i_req_sid  = '0;
    bus.i_req_ea   = '0;
    bus.o_cmd_r    = 1'b1;
    bus.i_host_v   = 1'b0;
    bus.i_host_tag = '0;
    bus.o_rsp_r    = 1'b1;
    repeat (2) tick();
    chk("rst_cmd_v", bus.o_cmd_v, 0);
    chk("rst_rsp_v", bus.o_rsp_v, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_req_r", bus.i_req_r, 1);
    chk("rst_host_r", bus.i_host_r, 1);
    reset = 1'b1;
    tick();

    // single request, then response and tag reuse
    push(5, 64'h1000);
    chk("t1_no_bypass", bus.o_cmd_v, 0);
    tick();
    chk("t1_cmd_v", bus.o_cmd_v, 1);
    chk("t1_cmd_tag", bus.o_cmd_tag, 0);
    chk("t1_cmd_ea", bus.o_cmd_ea, 64'h1000);
    tick();
    chk("t1_cmd_done", bus.o_cmd_v, 0);
    chk("t1_busy", o_busy, 1);
    host(0);
    chk("t1_rsp_v", bus.o_rsp_v, 1);
    chk("t1_rsp_sid", bus.o_rsp_sid, 5);
    chk("t1_busy_fall", o_busy, 0);
    chk("t1_no_err", o_err, 0);
    tick();
    chk("t1_rsp_drain", bus.o_rsp_v, 0);
    push(9, 64'h2000);
    tick();
    chk("t1_reuse_v", bus.o_cmd_v, 1);
    chk("t1_reuse_tag", bus.o_cmd_tag, 0);
    chk("t1_reuse_ea", bus.o_cmd_ea, 64'h2000);
    host(0);
    chk("t1_rsp2_sid", bus.o_rsp_sid, 9);
    tick();

    // response for a tag that was never issued
    host(12);
    chk("t4_err", o_err, 1);
    chk("t4_no_rsp", bus.o_rsp_v, 0);
    tick();
    chk("t4_err_pulse", o_err, 0);
    chk("t4_map_kept", o_busy, 0);

    // exhaust all tags, then fill the fifo
    q.delete();
    for (int i = 0; i < 36; i++)
      push(i, 64'h10000 + 64'(i) * 64);
    repeat (2) tick();
    chk("t2_req_r_full", bus.i_req_r, 0);
    chk("t2_issued", q.size(), 32);
    chk("t2_cmd_idle", bus.o_cmd_v, 0);
    bad = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag !== l2_tag_t'(i) ||
          q[i].ea !== 64'h10000 + 64'(i) * 64)
        bad++;
    chk("t2_order", bad, 0);
    host(7);
    chk("t2_rsp7_v", bus.o_rsp_v, 1);
    chk("t2_rsp7_sid", bus.o_rsp_sid, 7);
    chk("t2_no_same_cycle", bus.o_cmd_v, 0);
    tick();
    chk("t2_reissue_v", bus.o_cmd_v, 1);
    chk("t2_reissue_tag", bus.o_cmd_tag, 7);
    chk("t2_reissue_ea", bus.o_cmd_ea, 64'h10800);
    chk("t2_req_r_back", bus.i_req_r, 1);

    // hold off the command channel with requests queued
    bus.o_cmd_r = 1'b0;
    host(3);
    chk("t3_rsp3_sid", bus.o_rsp_sid, 3);
    host(4);
    chk("t3_rsp4_sid", bus.o_rsp_sid, 4);
    unst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_cmd_v !== 1'b1 ||
          bus.o_cmd_tag !== l2_tag_t'(7) ||
          bus.o_cmd_ea !== 64'h10800)
        unst++;
    end
    chk("t3_stable", unst, 0);
    chk("t3_no_handshake", q.size(), 32);
    q.delete();
    bus.o_cmd_r = 1'b1;
    repeat (4) tick();
    chk("t3_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("t3_tag0", q[0].tag, 7);
      chk("t3_tag1", q[1].tag, 3);
      chk("t3_ea1", q[1].ea, 64'h10840);
      chk("t3_tag2", q[2].tag, 4);
      chk("t3_ea2", q[2].ea, 64'h10880);
    end
`ifdef L2_TAG_STATS_EN
    chk("stat_issued", o_stat_issued, 37);
    chk("stat_peak", o_stat_peak, 32);
`endif

    // reset with all tags outstanding
    reset = 1'b0;
    #2;
    chk("t5_cmd_v", bus.o_cmd_v, 0);
    chk("t5_rsp_v", bus.o_rsp_v, 0);
    chk("t5_err", o_err, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_req_r", bus.i_req_r, 1);
    chk("t5_cmd_tag", bus.o_cmd_tag, 0);
`ifdef L2_TAG_STATS_EN
    chk("t5_stat_issued", o_stat_issued, 0);
    chk("t5_stat_peak", o_stat_peak, 0);
`endif
    tick();
    reset = 1'b1;
    tick();
    host(2);
    chk("t5_late_err", o_err, 1);
    chk("t5_late_no_rsp", bus.o_rsp_v, 0);
    tick();
    chk("t5_err_clear", o_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
